// File: rtl/led_fade_driver.sv
// led_fade_driver: turns the HPS LED PIO word into per-LED PWM drive.
// Each bit sets a target brightness of 0 or 255. Brightness walks toward
// its target by STEP once every FADE_TICK_DIV cycles and saturates at
// both ends. It then modulates a free-running 8-bit PWM.
//
// Optional feature macro: LED_FADE_EN
//   defined   - fading, prescaler and PWM are present.
//   undefined - brightness snaps to target, so led_out simply follows the
//               registered input. busy is tied low.
//
// Handshake note: there is no valid/ready flow here. leds_in is sampled
// every cycle, and every output is a plain registered level or pulse.
module led_fade_driver #(
    parameter int FADE_TICK_DIV = 50000,
    parameter int STEP          = 4
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [7:0] leds_in,
    output logic [7:0] led_out,
    output logic       pattern_changed,
    output logic       busy
);

    // Refuse to elaborate with parameters outside their legal range.
    if (FADE_TICK_DIV < 2 || FADE_TICK_DIV > (1 << 20) || STEP < 1 || STEP > 255) begin : g_bad_param
        $error("led_fade_driver: FADE_TICK_DIV or STEP out of range");
    end

    logic [7:0] leds_q;
    logic [7:0] leds_qd;

    // Register the PIO word twice and flag any change between the two copies.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            leds_q          <= 8'h00;
            leds_qd         <= 8'h00;
            pattern_changed <= 1'b0;
        end else begin
            leds_q          <= leds_in;
            leds_qd         <= leds_q;
            pattern_changed <= (leds_q != leds_qd);
        end
    end

`ifdef LED_FADE_EN

    // Per-LED fade direction. It is re-derived every cycle by comparing
    // brightness with target, and only acted on when tick is high.
    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_RISE = 2'd1,
        DIR_FALL = 2'd2
    } dir_e;

    localparam logic [19:0] PRE_LAST   = 20'(FADE_TICK_DIV - 1);
    localparam logic [7:0]  STEP_B     = 8'(STEP);
    localparam logic [7:0]  RISE_LIMIT = 8'(255 - STEP);

    logic [19:0] pre;
    logic        tick;
    logic [7:0]  pwm;
    logic [7:0]  target  [8];
    logic [7:0]  bri     [8];
    logic [7:0]  bri_nxt [8];
    dir_e        dir     [8];
    logic [7:0]  led_nxt;
    logic        busy_nxt;

    assign tick = (pre == PRE_LAST);

    // Fade-step prescaler: counts 0..FADE_TICK_DIV-1 and wraps.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            pre <= 20'd0;
        end else if (tick) begin
            pre <= 20'd0;
        end else begin
            pre <= pre + 20'd1;
        end
    end

    // Free-running PWM phase counter; wraps naturally from 255 to 0.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            pwm <= 8'h00;
        end else begin
            pwm <= pwm + 8'd1;
        end
    end

    // Expand each registered PIO bit into a full-scale brightness target.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            target[i] = leds_q[i] ? 8'hFF : 8'h00;
        end
    end

    // Direction decode, saturating brightness step, PWM compare and busy.
    always_comb begin
        busy_nxt = 1'b0;
        led_nxt  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            dir[i]     = DIR_IDLE;
            bri_nxt[i] = bri[i];
            if (bri[i] < target[i]) begin
                dir[i] = DIR_RISE;
            end else if (bri[i] > target[i]) begin
                dir[i] = DIR_FALL;
            end
            if (dir[i] != DIR_IDLE) begin
                busy_nxt = 1'b1;
            end
            if (tick) begin
                case (dir[i])
                    DIR_RISE: bri_nxt[i] = (bri[i] > RISE_LIMIT) ? 8'hFF : bri[i] + STEP_B;
                    DIR_FALL: bri_nxt[i] = (bri[i] < STEP_B) ? 8'h00 : bri[i] - STEP_B;
                    default:  bri_nxt[i] = bri[i];
                endcase
            end
            led_nxt[i] = (bri[i] == 8'hFF) | (bri[i] > pwm);
        end
    end

    // Brightness state plus registered LED drive and busy flag.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < 8; i++) begin
                bri[i] <= 8'h00;
            end
            led_out <= 8'h00;
            busy    <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                bri[i] <= bri_nxt[i];
            end
            led_out <= led_nxt;
            busy    <= busy_nxt;
        end
    end

`else

    // Without fading the brightness equals its 0/255 target. The PWM
    // compare therefore reduces to the registered input bit.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            led_out <= 8'h00;
        end else begin
            led_out <= leds_q;
        end
    end

    assign busy = 1'b0;

`endif

endmodule
